// File: rtl/lsq_issue_unit.sv
// lsq_issue_unit: issues pipeline memory ops to the LSQ and returns load data in order,
// tagged with the destination register, plus drain handshake, watchdog and sticky errors.
module lsq_issue_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_BITS = 5,
    parameter int MAX_OUT = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_is_store,
    input  logic [WIDTH-1:0]             in_addr,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [TAG_BITS-1:0]          in_tag,
    output logic                         lsq_req_valid,
    output logic [3:0]                   lsq_opcode,
    output logic [WIDTH-1:0]             lsq_addr,
    output logic [WIDTH-1:0]             lsq_data,
    input  logic                         lsq_store_full,
    input  logic                         lsq_load_full,
    input  logic                         lsq_load_valid,
    input  logic [WIDTH-1:0]             lsq_data_out,
    output logic                         wb_valid,
    output logic [TAG_BITS-1:0]          wb_tag,
    output logic [WIDTH-1:0]             wb_data,
    input  logic                         drain_req,
    output logic                         drain_done,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_timeout,
    output logic                         err_spurious
);
    localparam int CNT_BITS = $clog2(MAX_OUT + 1);
    localparam int PTR_BITS = $clog2(MAX_OUT);
    localparam int WD_BITS = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic [TAG_BITS-1:0] tags [MAX_OUT];
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0] count, count_next;
    logic [WD_BITS-1:0] wd;
    logic push, pop;

    // in_ready is forced low during reset so nothing is issued while state is being cleared
    assign in_ready = !rst && state == RUN &&
                      (in_is_store ? !lsq_store_full : (!lsq_load_full && count < CNT_BITS'(MAX_OUT)));
    assign lsq_req_valid = in_valid && in_ready;
    assign lsq_opcode = lsq_req_valid ? {3'b000, in_is_store} : 4'b0000;
    assign lsq_addr = lsq_req_valid ? in_addr : '0;
    assign lsq_data = (lsq_req_valid && in_is_store) ? in_data : '0;
    assign push = lsq_req_valid && !in_is_store;
    assign pop = lsq_load_valid && count != '0;
    assign count_next = count + CNT_BITS'(push) - CNT_BITS'(pop);
    assign outstanding = count;

    always_comb begin
        state_next = state;
        drain_done = state == DONE;
        if (state == RUN && drain_req) state_next = DRAIN;
        else if (state == DRAIN && count_next == '0) state_next = DONE;
        else if (state == DONE && !drain_req) state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= in_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wd <= '0;
            wb_valid <= 1'b0;
            wb_tag <= '0;
            wb_data <= '0;
            err_timeout <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            wb_valid <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                wb_tag <= tags[rd_ptr];
                wb_data <= lsq_data_out;
            end
            if (lsq_load_valid && count == '0) err_spurious <= 1'b1;
            // err_timeout rises on the same edge the watchdog reaches TIMEOUT
            if (count == '0 || lsq_load_valid) wd <= '0;
            else if (wd != WD_BITS'(TIMEOUT)) wd <= wd + 1'b1;
            if (count != '0 && !lsq_load_valid && wd == WD_BITS'(TIMEOUT - 1)) err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsq_issue_unit.sv
// tb_lsq_issue_unit: table-driven directed vectors plus hand sequences for capacity,
// watchdog, spurious response and drain.
module tb_lsq_issue_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_store;
    logic [31:0] in_addr, in_data;
    logic [4:0]  in_tag;
    logic        lsq_req_valid;
    logic [3:0]  lsq_opcode;
    logic [31:0] lsq_addr, lsq_data;
    logic        lsq_store_full, lsq_load_full, lsq_load_valid;
    logic [31:0] lsq_data_out;
    logic        wb_valid;
    logic [4:0]  wb_tag;
    logic [31:0] wb_data;
    logic        drain_req, drain_done;
    logic [3:0]  outstanding;
    logic        err_timeout, err_spurious;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsq_issue_unit #(.WIDTH(32), .TAG_BITS(5), .MAX_OUT(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag), .lsq_req_valid(lsq_req_valid),
        .lsq_opcode(lsq_opcode), .lsq_addr(lsq_addr), .lsq_data(lsq_data),
        .lsq_store_full(lsq_store_full), .lsq_load_full(lsq_load_full),
        .lsq_load_valid(lsq_load_valid), .lsq_data_out(lsq_data_out), .wb_valid(wb_valid),
        .wb_tag(wb_tag), .wb_data(wb_data), .drain_req(drain_req), .drain_done(drain_done),
        .outstanding(outstanding), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    typedef struct {
        logic v, st; logic [31:0] addr, data; logic [4:0] tag; logic sf, lf, lv; logic [31:0] dout;
        logic rdy, rv; logic [3:0] op; logic [31:0] laddr, ldata;
        logic wbv; logic [4:0] wbt; logic [31:0] wbd; logic [3:0] outs;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic v, st, input logic [31:0] addr, data, input logic [4:0] tag,
                                input logic sf, lf, lv, input logic [31:0] dout,
                                input logic rdy, rv, input logic [3:0] op, input logic [31:0] laddr, ldata,
                                input logic wbv, input logic [4:0] wbt, input logic [31:0] wbd,
                                input logic [3:0] outs);
        vec_t t;
        t.v = v; t.st = st; t.addr = addr; t.data = data; t.tag = tag;
        t.sf = sf; t.lf = lf; t.lv = lv; t.dout = dout;
        t.rdy = rdy; t.rv = rv; t.op = op; t.laddr = laddr; t.ldata = ldata;
        t.wbv = wbv; t.wbt = wbt; t.wbd = wbd; t.outs = outs;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; in_is_store = 0; in_addr = 0; in_data = 0; in_tag = 0;
        lsq_store_full = 0; lsq_load_full = 0; lsq_load_valid = 0; lsq_data_out = 0; drain_req = 0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [4:0] tag);
        in_valid = 1; in_is_store = 0; in_addr = addr; in_tag = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           v  st addr          data          tag sf lf lv dout            rdy rv op laddr        ldata         wbv wbt wbd           outs
        vecs[0]  = mk(1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0,            1, 1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0,            0);
        vecs[1]  = mk(1, 0, 32'h10,  32'h55,       3, 0, 0, 0, 0,            1, 1, 0, 32'h10,  0,            0, 0, 0,            1);
        vecs[2]  = mk(0, 0, 0,       0,            0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 0,       0,            1, 3, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 0, 0,       0,            0, 0, 0, 0, 0,            1, 0, 0, 0,       0,            0, 0, 0,            0);
        vecs[4]  = mk(1, 0, 32'h100, 0,            1, 0, 0, 0, 0,            1, 1, 0, 32'h100, 0,            0, 0, 0,            1);
        vecs[5]  = mk(1, 0, 32'h104, 0,            2, 0, 0, 0, 0,            1, 1, 0, 32'h104, 0,            0, 0, 0,            2);
        vecs[6]  = mk(1, 0, 32'h108, 0,            3, 0, 0, 0, 0,            1, 1, 0, 32'h108, 0,            0, 0, 0,            3);
        vecs[7]  = mk(0, 0, 0,       0,            0, 0, 0, 1, 32'hA,        1, 0, 0, 0,       0,            1, 1, 32'hA,        2);
        vecs[8]  = mk(1, 0, 32'h10C, 0,            4, 0, 0, 1, 32'hB,        1, 1, 0, 32'h10C, 0,            1, 2, 32'hB,        2);
        vecs[9]  = mk(0, 0, 0,       0,            0, 0, 0, 1, 32'hC,        1, 0, 0, 0,       0,            1, 3, 32'hC,        1);
        vecs[10] = mk(0, 0, 0,       0,            0, 0, 0, 0, 0,            1, 0, 0, 0,       0,            0, 0, 0,            1);
        vecs[11] = mk(1, 0, 32'h200, 0,            5, 0, 1, 0, 0,            0, 0, 0, 0,       0,            0, 0, 0,            1);
        vecs[12] = mk(1, 1, 32'h204, 32'h1234,     0, 0, 1, 0, 0,            1, 1, 1, 32'h204, 32'h1234,     0, 0, 0,            1);
        vecs[13] = mk(1, 1, 32'h208, 32'h99,       0, 1, 0, 0, 0,            0, 0, 0, 0,       0,            0, 0, 0,            1);
        vecs[14] = mk(0, 0, 0,       0,            0, 0, 0, 1, 32'hD,        1, 0, 0, 0,       0,            1, 4, 32'hD,        0);

        idle();
        rst = 1; in_valid = 1; in_is_store = 1;
        repeat (2) begin
            step();
            chk("rst in_ready", in_ready, 0);
            chk("rst req_valid", lsq_req_valid, 0);
            chk("rst wb_valid", wb_valid, 0);
            chk("rst outstanding", outstanding, 0);
            chk("rst err_timeout", err_timeout, 0);
            chk("rst err_spurious", err_spurious, 0);
        end
        rst = 0;
        idle();
        step();

        for (int i = 0; i < 15; i++) begin
            in_valid = vecs[i].v; in_is_store = vecs[i].st; in_addr = vecs[i].addr; in_data = vecs[i].data;
            in_tag = vecs[i].tag; lsq_store_full = vecs[i].sf; lsq_load_full = vecs[i].lf;
            lsq_load_valid = vecs[i].lv; lsq_data_out = vecs[i].dout;
            #1;
            chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].rdy);
            chk($sformatf("v%0d req_valid", i), lsq_req_valid, vecs[i].rv);
            chk($sformatf("v%0d opcode", i), lsq_opcode, vecs[i].op);
            chk($sformatf("v%0d lsq_addr", i), lsq_addr, vecs[i].laddr);
            chk($sformatf("v%0d lsq_data", i), lsq_data, vecs[i].ldata);
            step();
            chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].wbv);
            chk($sformatf("v%0d outstanding", i), outstanding, vecs[i].outs);
            if (vecs[i].wbv) begin
                chk($sformatf("v%0d wb_tag", i), wb_tag, vecs[i].wbt);
                chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].wbd);
            end
        end

        // capacity and watchdog: first push edge clears the watchdog, err_timeout 64 edges later
        idle();
        for (int i = 0; i < 8; i++) begin
            load(32'h300 + 32'(i * 4), 5'(i + 8));
            #1;
            chk($sformatf("cap%0d in_ready", i), in_ready, 1);
            step();
        end
        load(32'h400, 5'd20);
        #1;
        chk("full in_ready", in_ready, 0);
        chk("full req_valid", lsq_req_valid, 0);
        chk("full outstanding", outstanding, 8);
        repeat (56) @(posedge clk);
        #1;
        idle();
        chk("wd before timeout", err_timeout, 0);
        step();
        chk("wd at timeout", err_timeout, 1);
        for (int i = 0; i < 8; i++) begin
            lsq_load_valid = 1; lsq_data_out = 32'(i * 16 + 5);
            step();
            chk($sformatf("cap%0d wb_valid", i), wb_valid, 1);
            chk($sformatf("cap%0d wb_tag", i), wb_tag, 32'(i + 8));
            chk($sformatf("cap%0d wb_data", i), wb_data, 32'(i * 16 + 5));
        end
        lsq_load_valid = 0;
        step();
        chk("timeout sticky", err_timeout, 1);
        chk("cap outstanding", outstanding, 0);

        chk("spurious before", err_spurious, 0);
        lsq_load_valid = 1; lsq_data_out = 32'h77;
        step();
        lsq_load_valid = 0;
        chk("spurious flag", err_spurious, 1);
        chk("spurious wb_valid", wb_valid, 0);
        step();
        chk("spurious sticky", err_spurious, 1);

        load(32'h500, 5'd9);
        step();
        load(32'h504, 5'd10);
        step();
        idle();
        drain_req = 1;
        step();
        load(32'h508, 5'd11);
        #1;
        chk("drain in_ready", in_ready, 0);
        chk("drain req_valid", lsq_req_valid, 0);
        chk("drain done early", drain_done, 0);
        in_valid = 0;
        lsq_load_valid = 1; lsq_data_out = 32'h91;
        step();
        chk("drain resp1 done", drain_done, 0);
        chk("drain resp1 outstanding", outstanding, 1);
        lsq_data_out = 32'h92;
        step();
        lsq_load_valid = 0;
        chk("drain done", drain_done, 1);
        chk("drain outstanding", outstanding, 0);
        chk("drain wb_valid", wb_valid, 1);
        chk("drain wb_tag", wb_tag, 10);
        chk("drain wb_data", wb_data, 32'h92);
        load(32'h50C, 5'd12);
        #1;
        chk("done in_ready", in_ready, 0);
        step();
        chk("done held", drain_done, 1);
        drain_req = 0;
        step();
        chk("run drain_done", drain_done, 0);
        chk("run in_ready", in_ready, 1);
        chk("run outstanding", outstanding, 0);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
